// File: rtl/ej32_pkg.sv
// ej32_pkg: shared eJ32 core types.
//   DU         - data unit carried on the data stack
//   stack_op   - decoder -> data-stack command encoding
//   ds_state_t - data-stack controller sequencing states
package ej32_pkg;

    localparam int DU_W = 32;

    typedef logic [DU_W-1:0] DU;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        PUSH = 2'd1,
        PICK = 2'd2,
        POP  = 2'd3
    } stack_op;

    typedef enum logic [1:0] {
        DS_IDLE    = 2'd0,
        DS_POP_RD  = 2'd1,
        DS_PICK_RD = 2'd2
    } ds_state_t;

endpackage

// File: rtl/ej32_dstk_ctl.sv
// ej32_dstk_ctl: eJ32 data-stack controller.
// Keeps TOS in a register and spills everything below it into an external
// single-port RAM with one-cycle synchronous read. Owns depth, the derived
// stack pointer and the sticky overflow/underflow flags.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   op_valid/op_ready, op            command handshake and opcode
//   din, pick_idx                    PUSH data, PICK depth (0 = TOS)
//   tos, depth                       top of stack, element count incl. TOS
//   ovf, udf, flag_clr               sticky error flags and their clear
//   ram_addr/we/wdata, ram_rdata     stack RAM interface
module ej32_dstk_ctl
    import ej32_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int DSZ   = 32,
    parameter int ASZ   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           op_valid,
    output logic           op_ready,
    input  stack_op        op,
    input  logic [DSZ-1:0] din,
    input  logic [ASZ-1:0] pick_idx,
    output logic [DSZ-1:0] tos,
    output logic [ASZ:0]   depth,
    output logic           ovf,
    output logic           udf,
    input  logic           flag_clr,
    output logic [ASZ-1:0] ram_addr,
    output logic           ram_we,
    output logic [DSZ-1:0] ram_wdata,
    input  logic [DSZ-1:0] ram_rdata
);

    localparam logic [ASZ:0] FULL = (ASZ+1)'(DEPTH + 1);
    localparam logic [ASZ:0] ONE  = (ASZ+1)'(1);

    ds_state_t      state_q, state_d;
    logic [ASZ:0]   depth_q, depth_d;
    logic [DSZ-1:0] tos_q, tos_d;
    logic           ovf_q, ovf_d, udf_q, udf_d;
    logic           ovf_set, udf_set;

    logic           acc;
    logic [ASZ:0]   depth_m1;
    logic [ASZ-1:0] sp;
    logic [ASZ:0]   idx_ext;

    assign op_ready = (state_q == DS_IDLE);
    // Reset gates the accept so no RAM write can leak out while rst_n is low.
    assign acc      = op_valid & op_ready & rst_n;

    // The stack pointer is fully determined by depth, so it is derived
    // rather than stored; it can never drift out of sync with depth.
    assign depth_m1 = depth_q - ONE;
    assign sp       = (depth_q == '0) ? '0 : depth_m1[ASZ-1:0];
    assign idx_ext  = {1'b0, pick_idx};

    always_comb begin
        state_d   = state_q;
        depth_d   = depth_q;
        tos_d     = tos_q;
        ovf_set   = 1'b0;
        udf_set   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = tos_q;

        unique case (state_q)
            DS_IDLE: begin
                if (acc) begin
                    unique case (op)
                        NOP: ;
                        PUSH: begin
                            if (depth_q == FULL) begin
                                ovf_set = 1'b1;
                            end else if (depth_q == '0) begin
                                tos_d   = din;
                                depth_d = ONE;
                            end else begin
                                ram_we   = 1'b1;
                                ram_addr = sp;
                                tos_d    = din;
                                depth_d  = depth_q + ONE;
                            end
                        end
                        POP: begin
                            if (depth_q == '0) begin
                                udf_set = 1'b1;
                            end else if (depth_q == ONE) begin
                                tos_d   = '0;
                                depth_d = '0;
                            end else begin
                                ram_addr = sp - ASZ'(1);
                                depth_d  = depth_q - ONE;
                                state_d  = DS_POP_RD;
                            end
                        end
                        PICK: begin
                            // Underflow is checked first so an empty stack
                            // always reports udf, never ovf.
                            if (idx_ext >= depth_q) begin
                                udf_set = 1'b1;
                            end else if (depth_q == FULL) begin
                                ovf_set = 1'b1;
                            end else if (pick_idx == '0) begin
                                // DUP: spill TOS, TOS itself is unchanged.
                                ram_we   = 1'b1;
                                ram_addr = sp;
                                depth_d  = depth_q + ONE;
                            end else begin
                                ram_addr = sp - pick_idx;
                                state_d  = DS_PICK_RD;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            DS_POP_RD: begin
                tos_d   = ram_rdata;
                state_d = DS_IDLE;
            end
            DS_PICK_RD: begin
                // Read of the picked element completed; spill old TOS in
                // the same cycle (single-port RAM is free again).
                ram_we   = 1'b1;
                ram_addr = sp;
                tos_d    = ram_rdata;
                depth_d  = depth_q + ONE;
                state_d  = DS_IDLE;
            end
            default: state_d = DS_IDLE;
        endcase

        // Set wins over a simultaneous clear.
        ovf_d = ovf_set | (ovf_q & ~flag_clr);
        udf_d = udf_set | (udf_q & ~flag_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DS_IDLE;
            depth_q <= '0;
            tos_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            tos_q   <= tos_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign tos   = tos_q;
    assign depth = depth_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: tb/tb_ej32_dstk_ctl.sv
// Bench for ej32_dstk_ctl with DEPTH=8: directed sequences from the test
// plan followed by randomized commands, checked against a queue-based stack
// model. A behavioural sync-read RAM sits on the RAM port.
module tb_ej32_dstk_ctl;
    import ej32_pkg::*;

    localparam int DEPTH = 8;
    localparam int DSZ   = 32;
    localparam int ASZ   = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           op_valid = 1'b0;
    logic           op_ready;
    stack_op        op = NOP;
    logic [DSZ-1:0] din = '0;
    logic [ASZ-1:0] pick_idx = '0;
    logic [DSZ-1:0] tos;
    logic [ASZ:0]   depth;
    logic           ovf, udf;
    logic           flag_clr = 1'b0;
    logic [ASZ-1:0] ram_addr;
    logic           ram_we;
    logic [DSZ-1:0] ram_wdata;
    logic [DSZ-1:0] ram_rdata;

    ej32_dstk_ctl #(.DEPTH(DEPTH), .DSZ(DSZ), .ASZ(ASZ)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .din(din), .pick_idx(pick_idx), .tos(tos), .depth(depth),
        .ovf(ovf), .udf(udf), .flag_clr(flag_clr), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM, read data one cycle after address.
    logic [DSZ-1:0] mem [DEPTH];
    int             we_cnt = 0;
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            we_cnt        <= we_cnt + 1;
        end
        ram_rdata <= mem[ram_addr];
    end

    // Reference model: element 0 is the bottom, the last element is TOS.
    int unsigned stk[$];
    bit          m_ovf = 0, m_udf = 0;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned m_tos();
        return (stk.size() == 0) ? 0 : stk[stk.size()-1];
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, ".tos"},   tos,      m_tos());
        chk({tag, ".depth"}, depth,    stk.size());
        chk({tag, ".ovf"},   ovf,      m_ovf);
        chk({tag, ".udf"},   udf,      m_udf);
        chk({tag, ".rdy"},   op_ready, 1);
    endtask

    task automatic chk_ram(input string tag);
        for (int i = 0; i < stk.size() - 1; i++)
            chk($sformatf("%s.ram%0d", tag, i), mem[i], stk[i]);
    endtask

    // Drive one command at a negedge, let it be accepted, then check.
    task automatic do_op(input string tag, input bit v, input stack_op o,
                         input logic [31:0] d, input int idx, input bit clr);
        bit set_o, set_u, multi;
        int n;
        n = 0;
        while (op_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".rdy_in"}, op_ready, 1);
        op_valid = v; op = o; din = d; pick_idx = idx[ASZ-1:0]; flag_clr = clr;
        set_o = 0; set_u = 0; multi = 0;
        if (v) begin
            case (o)
                PUSH: if (stk.size() == DEPTH + 1) set_o = 1; else stk.push_back(d);
                POP: begin
                    if (stk.size() == 0) set_u = 1;
                    else begin
                        multi = (stk.size() > 1);
                        void'(stk.pop_back());
                    end
                end
                PICK: begin
                    if (idx >= stk.size()) set_u = 1;
                    else if (stk.size() == DEPTH + 1) set_o = 1;
                    else begin
                        multi = (idx != 0);
                        stk.push_back(stk[stk.size() - 1 - idx]);
                    end
                end
                default: ;
            endcase
        end
        m_ovf = set_o | (m_ovf & !clr);
        m_udf = set_u | (m_udf & !clr);
        @(negedge clk);
        op_valid = 0; flag_clr = 0; op = NOP;
        if (multi) begin
            chk({tag, ".busy"}, op_ready, 0);
            @(negedge clk);
        end
        chk_state(tag);
    endtask

    int wc;

    initial begin
        #1;
        chk("rst.tos", tos, 0);
        chk("rst.depth", depth, 0);
        chk("rst.rdy", op_ready, 1);
        chk("rst.we", ram_we, 0);
        chk("rst.addr", ram_addr, 0);
        chk("rst.flags", {ovf, udf}, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Back-to-back pushes, then pops down past empty.
        do_op("push11", 1, PUSH, 32'h11, 0, 0);
        do_op("push22", 1, PUSH, 32'h22, 0, 0);
        do_op("push33", 1, PUSH, 32'h33, 0, 0);
        chk("p3.tos", tos, 32'h33);
        chk("p3.depth", depth, 3);
        chk_ram("p3");
        do_op("pop1", 1, POP, 0, 0, 0);
        chk("pop1.tos", tos, 32'h22);
        do_op("pop2", 1, POP, 0, 0, 0);
        chk("pop2.tos", tos, 32'h11);
        do_op("pop3", 1, POP, 0, 0, 0);
        chk("pop3.depth", depth, 0);
        do_op("pop4", 1, POP, 0, 0, 0);
        chk("pop4.udf", udf, 1);
        do_op("clr", 1, NOP, 0, 0, 1);

        // Fill to DEPTH+1, overflow, clear, set-vs-clear.
        for (int i = 0; i < DEPTH + 1; i++)
            do_op($sformatf("fill%0d", i), 1, PUSH, 32'h100 + i, 0, 0);
        chk_ram("full");
        do_op("ovf", 1, PUSH, 32'hAA, 0, 0);
        chk("ovf.flag", ovf, 1);
        do_op("ovfclr", 1, NOP, 0, 0, 1);
        chk("ovfclr.flag", ovf, 0);
        do_op("ovfwin", 1, PUSH, 32'hAA, 0, 1);
        chk("ovfwin.flag", ovf, 1);
        do_op("pickfull", 1, PICK, 0, 1, 1);
        while (stk.size() > 0) do_op("drain", 1, POP, 0, 0, 0);
        do_op("clr2", 1, NOP, 0, 0, 1);

        // PICK cases.
        do_op("pk_p1", 1, PUSH, 32'h11, 0, 0);
        do_op("pk_p2", 1, PUSH, 32'h22, 0, 0);
        do_op("pk_p3", 1, PUSH, 32'h33, 0, 0);
        do_op("pick2", 1, PICK, 0, 2, 0);
        chk("pick2.tos", tos, 32'h11);
        chk("pick2.ram2", mem[2], 32'h33);
        do_op("pick0", 1, PICK, 0, 0, 0);
        chk("pick0.depth", depth, 5);
        chk_ram("pick");
        do_op("pick5", 1, PICK, 0, 5, 0);
        chk("pick5.udf", udf, 1);

        // Reset in the POP_RD cycle.
        @(negedge clk);
        op_valid = 1; op = POP;
        @(posedge clk);
        #1;
        op_valid = 0; op = NOP;
        chk("poprd.busy", op_ready, 0);
        rst_n = 0;
        #1;
        chk("arst.tos", tos, 0);
        chk("arst.depth", depth, 0);
        chk("arst.rdy", op_ready, 1);
        chk("arst.we", ram_we, 0);
        chk("arst.addr", ram_addr, 0);
        chk("arst.flags", {ovf, udf}, 0);
        wc = we_cnt;
        @(negedge clk);
        @(negedge clk);
        chk("arst.nowe", we_cnt, wc);
        rst_n = 1;
        stk.delete(); m_ovf = 0; m_udf = 0;
        @(negedge clk);
        chk_state("arel");

        // PUSH/NOP with toggling valid.
        for (int i = 0; i < 40; i++)
            do_op("gap", ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1) ? PUSH : NOP, $urandom, 0, 0);
        chk_ram("gap");

        // Fully random command mix.
        for (int i = 0; i < 300; i++) begin
            stack_op ro;
            ro = stack_op'($urandom_range(0, 3));
            do_op("rnd", ($urandom_range(0, 3) != 0), ro, $urandom,
                  $urandom_range(0, ASZ == 3 ? 7 : 0), ($urandom_range(0, 7) == 0));
            if (i % 25 == 0) chk_ram("rnd");
        end
        chk_ram("end");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule
